// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port, fixed-latency memory.
// Optional grant/conflict counters are compiled in when ARB_PERF_EN is defined.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_done,
    output logic [DW-1:0] p0_rdata,

    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_done,
    output logic [DW-1:0] p1_rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

`ifdef ARB_PERF_EN
    output logic [15:0]   p0_cnt,
    output logic [15:0]   p1_cnt,
    output logic [15:0]   conflict_cnt,
`endif
    output logic          busy
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            last_grant_q, last_grant_d;
    logic            winner_q, winner_d;

    logic            p0_gnt_q, p0_gnt_d;
    logic            p1_gnt_q, p1_gnt_d;
    logic            p0_done_q, p0_done_d;
    logic            p1_done_q, p1_done_d;
    logic [DW-1:0]   p0_rdata_q, p0_rdata_d;
    logic [DW-1:0]   p1_rdata_q, p1_rdata_d;

    logic            mem_en_q, mem_en_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic            busy_q, busy_d;

    logic            start;
    logic            sel;

    assign start = (state_q == IDLE) && (p0_req || p1_req);
    // On a conflict the port that did not win last time goes next.
    assign sel   = (p0_req && p1_req) ? ~last_grant_q : p1_req;

    always_comb begin
        // NOTE: every next-state value gets a default first so no latch is inferred.
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        winner_d     = winner_q;
        p0_gnt_d     = 1'b0;
        p1_gnt_d     = 1'b0;
        p0_done_d    = 1'b0;
        p1_done_d    = 1'b0;
        p0_rdata_d   = p0_rdata_q;
        p1_rdata_d   = p1_rdata_q;
        mem_en_d     = mem_en_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = ACCESS;
                    cnt_d        = CW'(MEM_LAT - 1);
                    winner_d     = sel;
                    last_grant_d = sel;
                    p0_gnt_d     = ~sel;
                    p1_gnt_d     = sel;
                    mem_en_d     = 1'b1;
                    mem_we_d     = sel ? p1_we    : p0_we;
                    mem_addr_d   = sel ? p1_addr  : p0_addr;
                    mem_wdata_d  = sel ? p1_wdata : p0_wdata;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d   = RESP;
                    mem_en_d  = 1'b0;
                    mem_we_d  = 1'b0;
                    p0_done_d = ~winner_q;
                    p1_done_d = winner_q;
                    if (!mem_we_q) begin
                        if (winner_q) p1_rdata_d = mem_rdata;
                        else          p0_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            winner_q     <= 1'b0;
            p0_gnt_q     <= 1'b0;
            p1_gnt_q     <= 1'b0;
            p0_done_q    <= 1'b0;
            p1_done_q    <= 1'b0;
            p0_rdata_q   <= '0;
            p1_rdata_q   <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            winner_q     <= winner_d;
            p0_gnt_q     <= p0_gnt_d;
            p1_gnt_q     <= p1_gnt_d;
            p0_done_q    <= p0_done_d;
            p1_done_q    <= p1_done_d;
            p0_rdata_q   <= p0_rdata_d;
            p1_rdata_q   <= p1_rdata_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            busy_q       <= busy_d;
        end
    end

    assign p0_gnt    = p0_gnt_q;
    assign p1_gnt    = p1_gnt_q;
    assign p0_done   = p0_done_q;
    assign p1_done   = p1_done_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

`ifdef ARB_PERF_EN
    logic        conflict;
    logic [15:0] p0_cnt_q, p1_cnt_q, conflict_cnt_q;

    assign conflict = (state_q == IDLE) && p0_req && p1_req;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            p0_cnt_q       <= '0;
            p1_cnt_q       <= '0;
            conflict_cnt_q <= '0;
        end else begin
            if (start && !sel && p0_cnt_q != 16'hFFFF)
                p0_cnt_q <= p0_cnt_q + 16'd1;
            if (start && sel && p1_cnt_q != 16'hFFFF)
                p1_cnt_q <= p1_cnt_q + 16'd1;
            if (conflict && conflict_cnt_q != 16'hFFFF)
                conflict_cnt_q <= conflict_cnt_q + 16'd1;
        end
    end

    assign p0_cnt       = p0_cnt_q;
    assign p1_cnt       = p1_cnt_q;
    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates one shared single-port memory between two requesters: port 0 (CPU multicycle controller, IF/MEM accesses) and port 1 (program loader / DMA).
- Sits between the requesters and the unified instruction/data memory.
- Round-robin when both request; fixed-latency memory sequenced by an internal counter; one transaction in flight at a time.

Parameters:
AW, 32, address width
DW, 32, data width
MEM_LAT, 2, memory access cycles (>=1); mem_rdata valid in the last access cycle

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
p0_req  in  1  port 0 request (level)
p0_we  in  1  port 0 write enable (0 = read)
p0_addr  in  AW  port 0 address
p0_wdata  in  DW  port 0 write data
p0_gnt  out  1  port 0 grant pulse; payload latched
p0_done  out  1  port 0 completion pulse
p0_rdata  out  DW  port 0 read data, held until the next port 0 read completes
p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_done, p1_rdata  same as port 0, for port 1
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data
busy  out  1  high whenever state != IDLE

Behaviour:
- One clock (clk). Reset is synchronous and active-low: sampled only on the rising clk edge when reset = 0.
- On reset: state=IDLE; all gnt/done/mem_* outputs 0; p0_rdata=p1_rdata=0; busy=0; last_grant=1, so port 0 wins the first conflict.
- All outputs are registered.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - Request sampled at cycle N.
  - If only one req is high, that port wins.
  - If both are high, the port != last_grant wins.
  - At edge N: latch winner's we/addr/wdata; set last_grant=winner; load counter=MEM_LAT-1; go to ACCESS.
- ACCESS (cycles N+1 .. N+MEM_LAT):
  - mem_en=1; mem_we/mem_addr/mem_wdata come from the latched payload and are stable throughout.
  - gnt of the winner is high only in cycle N+1.
  - Counter decrements each cycle. When counter==0: capture mem_rdata into the winner's rdata if read; go to RESP.
- RESP (cycle N+MEM_LAT+1):
  - mem_en=0; winner's done=1 for exactly one cycle; next state is IDLE.
  - Write transactions leave rdata unchanged.
- Total latency, req sampled to done: MEM_LAT+1 cycles. Minimum spacing between grants: MEM_LAT+2 cycles.
- Handshake:
  - Requester holds req and payload stable until it sees gnt.
  - Payload may change after gnt.
  - Each IDLE cycle with req high starts a new transaction. A requester wanting a single access must deassert req no later than the cycle after done.
  - A loser's req stays pending and is served on the next IDLE cycle; no request is dropped.
- Requests arriving while not IDLE are ignored until IDLE. Requests are never queued beyond the level of req.
- Same port requesting continuously while the other is idle: served back-to-back, no fairness penalty.
- Reset low mid-ACCESS or mid-RESP:
  - Transaction abandoned; no done issued.
  - mem_en=0 from the next cycle; state=IDLE; last_grant=1.
- MEM_LAT=1: ACCESS lasts exactly one cycle, and gnt and mem_en coincide with the rdata capture cycle.

Optional Feature:
- Macro: ARB_PERF_EN.
- Defined:
  - Adds outputs p0_cnt[15:0], p1_cnt[15:0] (grants per port) and conflict_cnt[15:0] (IDLE cycles where both reqs are high).
  - All counters reset to 0, saturate at 16'hFFFF, and increment at the grant edge / conflict cycle.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Single port 0 read, MEM_LAT=2, addr=0x10, mem returns 0xDEADBEEF in the last access cycle -> p0_gnt in cycle 1, mem_en in cycles 1-2, p0_done in cycle 3, p0_rdata=0xDEADBEEF, busy low from cycle 4.
- Both ports request in the same cycle, held high for 3 transactions -> grant order p0, p1, p0; no port granted twice consecutively; conflict_cnt=3 with ARB_PERF_EN.
- Port 1 write addr=0x20 wdata=0x12345678 -> mem_we=1, mem_addr=0x20, mem_wdata=0x12345678 for MEM_LAT cycles; p1_done once; p1_rdata unchanged.
- Port 1 req rises while port 0 is in ACCESS -> p1 ignored until IDLE, then granted in the cycle after the IDLE sample; p0 transaction unaffected.
- Reset driven low in the first ACCESS cycle -> no done pulse, mem_en=0 the next cycle, busy=0; with both reqs then high, port 0 wins.
- MEM_LAT=1, port 0 read -> gnt, mem_en and rdata capture in cycle 1; done in cycle 2.
